// File: rtl/dma_utils_pkg.sv
// Shared types and constants for the DMA accelerator wrapper stages.
// DMA_DATA_WIDTH sets the DMA word width used as the default input width.
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 32
`endif

package dma_utils_pkg;

    typedef enum logic [1:0] {UNPK_IDLE, UNPK_RUN, UNPK_DONE} dma_unpk_st_t;

    localparam int DMA_UNPK_OUT_W = 8;

    // Lane-index width; keeps at least one bit when there is a single lane.
    function automatic int dma_lane_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/dma_stream_unpacker.sv
// dma_stream_unpacker: splits DMA words into framed narrow beats, lane 0 first.
// Optional booleanised output enabled by defining DMA_UNPACK_BOOL_EN.
module dma_stream_unpacker
    import dma_utils_pkg::*;
#(
    parameter int DATA_W = `DMA_DATA_WIDTH,
    parameter int OUT_W  = DMA_UNPK_OUT_W,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [LEN_W-1:0]  frame_len_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic [OUT_W-1:0]  m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_last_o,
    output logic              busy_o,
    output logic              frame_done_o
`ifdef DMA_UNPACK_BOOL_EN
    ,
    input  logic [OUT_W-1:0]  thresh_i,
    output logic              m_bool_o
`endif
);

    localparam int RATIO  = DATA_W / OUT_W;
    localparam int LANE_W = dma_lane_w(RATIO);

    if ((DATA_W % OUT_W) != 0) begin : g_bad_ratio
        $error("dma_stream_unpacker: DATA_W must be a multiple of OUT_W");
    end

    dma_unpk_st_t      r_state;
    dma_unpk_st_t      w_next_state;
    logic [DATA_W-1:0] r_word;
    logic [LANE_W-1:0] r_lane;
    logic              r_full;
    logic [LEN_W-1:0]  r_beats_left;
    logic [LEN_W-1:0]  r_words_left;

    logic              w_run;
    logic              w_out_fire;
    logic              w_in_fire;
    logic              w_lane_end;
    logic              w_start_run;
    logic [LEN_W:0]    w_len_ext;
    logic [LEN_W-1:0]  w_words;

    // Word count rounded up; one extra bit so the rounding add cannot wrap.
    assign w_len_ext   = {1'b0, frame_len_i} + (LEN_W+1)'(RATIO - 1);
    assign w_words     = LEN_W'(w_len_ext / (LEN_W+1)'(RATIO));

    assign w_run       = (r_state == UNPK_RUN);
    assign w_lane_end  = (r_lane == LANE_W'(RATIO - 1));
    assign w_out_fire  = m_valid_o & m_ready_i;
    assign w_in_fire   = s_ready_o & s_valid_i;
    assign w_start_run = (r_state == UNPK_IDLE) & start_i & (frame_len_i != '0);

    // Refill is allowed in the same cycle the last lane drains.
    assign s_ready_o    = w_run & (r_words_left != '0) & (~r_full | (w_out_fire & w_lane_end));
    assign m_valid_o    = r_full & w_run;
    assign m_data_o     = r_word[r_lane*OUT_W +: OUT_W];
    assign m_last_o     = (r_beats_left == LEN_W'(1));
    assign busy_o       = (r_state != UNPK_IDLE);
    assign frame_done_o = (r_state == UNPK_DONE);

`ifdef DMA_UNPACK_BOOL_EN
    assign m_bool_o = m_valid_o & (m_data_o >= thresh_i);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= UNPK_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            UNPK_IDLE: begin
                if (start_i) begin
                    w_next_state = (frame_len_i != '0) ? UNPK_RUN : UNPK_DONE;
                end
            end
            UNPK_RUN: begin
                if (w_out_fire & m_last_o) begin
                    w_next_state = UNPK_DONE;
                end
            end
            UNPK_DONE: w_next_state = UNPK_IDLE;
            default:   w_next_state = UNPK_IDLE;
        endcase
        if (abort_i) begin
            w_next_state = UNPK_IDLE;
        end
    end

    // Holding register, lane pointer and frame counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word       <= '0;
            r_lane       <= '0;
            r_full       <= 1'b0;
            r_beats_left <= '0;
            r_words_left <= '0;
        end else if (abort_i) begin
            r_word       <= '0;
            r_lane       <= '0;
            r_full       <= 1'b0;
            r_beats_left <= '0;
            r_words_left <= '0;
        end else if (w_start_run) begin
            r_lane       <= '0;
            r_full       <= 1'b0;
            r_beats_left <= frame_len_i;
            r_words_left <= w_words;
        end else if (w_run) begin
            // A refill only coincides with a drain on the final lane, so it
            // simply overrides the lane/full update of that drain.
            if (w_in_fire) begin
                r_word       <= s_data_i;
                r_lane       <= '0;
                r_full       <= 1'b1;
                r_words_left <= r_words_left - 1'b1;
            end else if (w_out_fire) begin
                r_lane <= w_lane_end ? '0 : r_lane + 1'b1;
                if (w_lane_end | m_last_o) begin
                    r_full <= 1'b0;
                end
            end
            if (w_out_fire) begin
                r_beats_left <= r_beats_left - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_stream_unpacker.sv
// Directed bench for dma_stream_unpacker (32-bit words, 8-bit beats).
module tb_dma_stream_unpacker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [15:0] frame_len_i = '0;
    logic [31:0] s_data_i = '0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [7:0]  m_data_o;
    logic        m_valid_o;
    logic        m_ready_i = 1'b0;
    logic        m_last_o;
    logic        busy_o;
    logic        frame_done_o;
`ifdef DMA_UNPACK_BOOL_EN
    logic [7:0]  thresh_i = '0;
    logic        m_bool_o;
`endif

    always #5 clk = ~clk;

    dma_stream_unpacker #(.DATA_W(32), .OUT_W(8), .LEN_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .frame_len_i  (frame_len_i),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_last_o     (m_last_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
`ifdef DMA_UNPACK_BOOL_EN
        ,
        .thresh_i     (thresh_i),
        .m_bool_o     (m_bool_o)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Records filled by drive_frame for the scenario tasks to judge.
    logic [31:0] src_words[$];
    logic [7:0]  got_beats[$];
    bit          got_last[$];
    bit          got_bool[$];
    int accepts, done_cnt, done_cyc, last_cyc, stall_err, timed_out;
    int busy_after_done, any_sready, any_mvalid, post_abort_act, aborted_at;

    task automatic drive_frame(input int len, input bit rnd_ready, input bit rnd_valid,
                               input int abort_after, input int budget);
        int  cyc;
        int  widx;
        bit  finished;
        bit  prev_stall;
        logic [7:0] prev_data;
        bit  prev_last;
        got_beats.delete(); got_last.delete(); got_bool.delete();
        accepts = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1; stall_err = 0;
        timed_out = 0; busy_after_done = -1; any_sready = 0; any_mvalid = 0;
        post_abort_act = -1; aborted_at = -1;
        widx = 0; finished = 0; prev_stall = 0; prev_data = '0; prev_last = 0; cyc = 0;
        @(negedge clk);
        frame_len_i = 16'(len);
        start_i = 1'b1;
        @(negedge clk);
        while (!finished) begin
            start_i = 1'b0;
            if (cyc >= budget) begin
                timed_out = 1;
                break;
            end
            if (abort_after >= 0 && aborted_at < 0 && got_beats.size() == abort_after) begin
                abort_i = 1'b1; m_ready_i = 1'b0; s_valid_i = 1'b0;
                aborted_at = cyc;
            end else begin
                abort_i = 1'b0;
                s_valid_i = (aborted_at < 0) && (widx < src_words.size()) &&
                            (!rnd_valid || ($urandom_range(1, 0) == 1));
                s_data_i  = (widx < src_words.size()) ? src_words[widx] : 32'h0;
                m_ready_i = (aborted_at < 0) && (!rnd_ready || ($urandom_range(1, 0) == 1));
            end
            #1;
            if (prev_stall && (!m_valid_o || m_data_o !== prev_data || m_last_o !== prev_last))
                stall_err++;
            prev_stall = m_valid_o && !m_ready_i && !abort_i;
            prev_data  = m_data_o;
            prev_last  = m_last_o;
            if (s_ready_o) any_sready = 1;
            if (m_valid_o) any_mvalid = 1;
            if (s_valid_i && s_ready_o) begin
                accepts++;
                widx++;
            end
            if (m_valid_o && m_ready_i) begin
                got_beats.push_back(m_data_o);
                got_last.push_back(m_last_o);
`ifdef DMA_UNPACK_BOOL_EN
                got_bool.push_back(m_bool_o);
`endif
                if (m_last_o && last_cyc < 0) last_cyc = cyc;
            end
            if (frame_done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after_done = busy_o;
            if (aborted_at >= 0 && cyc == aborted_at + 1)
                post_abort_act = busy_o | m_valid_o | s_ready_o;
            if ((done_cyc >= 0 && cyc >= done_cyc + 3) || (aborted_at >= 0 && cyc >= aborted_at + 4))
                finished = 1;
            cyc++;
            @(negedge clk);
        end
        s_valid_i = 1'b0; m_ready_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%b exp=0", s_ready_o); end
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid_o); end
        checks++; if (m_last_o !== 1'b0) begin errors++; $display("FAIL reset_m_last got=%b exp=0", m_last_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done_o); end
        checks++; if (m_data_o !== 8'h00) begin errors++; $display("FAIL reset_m_data got=%h exp=00", m_data_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_frame;
        src_words = '{32'h44332211, 32'h88776655};
        drive_frame(8, 0, 0, -1, 200);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL full_timeout got=%0d exp=0", timed_out); end
        checks++; if (got_beats.size() !== 8) begin errors++; $display("FAIL full_count got=%0d exp=8", got_beats.size()); end
        for (int i = 0; i < 8 && i < got_beats.size(); i++) begin
            checks++;
            if (got_beats[i] !== 8'(8'h11 * (i + 1)) || got_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL full_beat%0d got=%h/last%b exp=%h/last%b", i, got_beats[i], got_last[i], 8'(8'h11 * (i + 1)), (i == 7));
            end
        end
        checks++; if (last_cyc !== 8) begin errors++; $display("FAIL full_last_cycle got=%0d exp=8", last_cyc); end
        checks++; if (done_cyc !== last_cyc + 1) begin errors++; $display("FAIL full_done_cycle got=%0d exp=%0d", done_cyc, last_cyc + 1); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL full_done_count got=%0d exp=1", done_cnt); end
        checks++; if (accepts !== 2) begin errors++; $display("FAIL full_accepts got=%0d exp=2", accepts); end
        checks++; if (busy_after_done !== 0) begin errors++; $display("FAIL full_busy_after got=%0d exp=0", busy_after_done); end
    endtask

    task automatic test_truncated;
        logic [7:0] exp_b [5];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        src_words = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
        drive_frame(5, 0, 0, -1, 200);
        checks++; if (got_beats.size() !== 5) begin errors++; $display("FAIL trunc_count got=%0d exp=5", got_beats.size()); end
        for (int i = 0; i < 5 && i < got_beats.size(); i++) begin
            checks++;
            if (got_beats[i] !== exp_b[i] || got_last[i] !== (i == 4)) begin
                errors++;
                $display("FAIL trunc_beat%0d got=%h/last%b exp=%h/last%b", i, got_beats[i], got_last[i], exp_b[i], (i == 4));
            end
        end
        checks++; if (accepts !== 2) begin errors++; $display("FAIL trunc_accepts got=%0d exp=2", accepts); end
        checks++; if (done_cyc !== last_cyc + 1 || last_cyc < 0) begin errors++; $display("FAIL trunc_done_cycle got=%0d exp=%0d", done_cyc, last_cyc + 1); end
    endtask

    task automatic test_zero_len;
        src_words = '{32'h44332211};
        drive_frame(0, 0, 0, -1, 50);
        checks++; if (done_cyc !== 0) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=0", done_cyc); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
        checks++; if (any_sready !== 0) begin errors++; $display("FAIL zero_s_ready got=%0d exp=0", any_sready); end
        checks++; if (any_mvalid !== 0) begin errors++; $display("FAIL zero_m_valid got=%0d exp=0", any_mvalid); end
    endtask

    task automatic test_random_stall;
        int bad;
        int first_bad;
        int lasts;
        logic [7:0] e;
        src_words.delete();
        for (int w = 0; w < 250; w++) begin
            logic [31:0] wd;
            for (int l = 0; l < 4; l++) wd[l*8 +: 8] = 8'(((w * 4 + l) * 37 + 11) & 255);
            src_words.push_back(wd);
        end
        drive_frame(1000, 1, 1, -1, 20000);
        bad = 0; first_bad = -1; lasts = 0;
        for (int k = 0; k < got_beats.size(); k++) begin
            e = 8'((k * 37 + 11) & 255);
            if (got_beats[k] !== e) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (got_last[k]) lasts++;
        end
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL rand_timeout got=%0d exp=0", timed_out); end
        checks++; if (got_beats.size() !== 1000) begin errors++; $display("FAIL rand_count got=%0d exp=1000", got_beats.size()); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rand_data bad_beats=%0d first_at=%0d exp=0", bad, first_bad); end
        checks++; if (stall_err !== 0) begin errors++; $display("FAIL rand_stall_stable got=%0d exp=0", stall_err); end
        checks++; if (accepts !== 250) begin errors++; $display("FAIL rand_accepts got=%0d exp=250", accepts); end
        checks++; if (lasts !== 1 || got_beats.size() == 0 || got_last[got_last.size()-1] !== 1'b1) begin
            errors++; $display("FAIL rand_last lasts=%0d exp=1 on final beat", lasts);
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rand_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_abort_restart;
        logic [7:0] exp_b [4];
        exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        src_words = '{32'h44332211, 32'h88776655};
        drive_frame(8, 0, 0, 3, 200);
        checks++; if (got_beats.size() !== 3) begin errors++; $display("FAIL abort_beats got=%0d exp=3", got_beats.size()); end
        checks++; if (post_abort_act !== 0) begin errors++; $display("FAIL abort_idle got=%0d exp=0", post_abort_act); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
        src_words = '{32'hDDCCBBAA};
        drive_frame(4, 0, 0, -1, 200);
        checks++; if (got_beats.size() !== 4) begin errors++; $display("FAIL restart_count got=%0d exp=4", got_beats.size()); end
        for (int i = 0; i < 4 && i < got_beats.size(); i++) begin
            checks++;
            if (got_beats[i] !== exp_b[i] || got_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL restart_beat%0d got=%h/last%b exp=%h/last%b", i, got_beats[i], got_last[i], exp_b[i], (i == 3));
            end
        end
        checks++; if (done_cnt !== 1 || accepts !== 1) begin errors++; $display("FAIL restart_done_accepts got=%0d/%0d exp=1/1", done_cnt, accepts); end
    endtask

`ifdef DMA_UNPACK_BOOL_EN
    task automatic test_bool;
        bit exp_q [4];
        exp_q = '{1'b0, 1'b1, 1'b1, 1'b0};
        thresh_i = 8'h40;
        src_words = '{32'h00FF403F};
        drive_frame(4, 0, 0, -1, 200);
        checks++; if (got_bool.size() !== 4) begin errors++; $display("FAIL bool_count got=%0d exp=4", got_bool.size()); end
        for (int i = 0; i < 4 && i < got_bool.size(); i++) begin
            checks++;
            if (got_bool[i] !== exp_q[i]) begin
                errors++; $display("FAIL bool_beat%0d got=%b exp=%b", i, got_bool[i], exp_q[i]);
            end
        end
        checks++; if (m_bool_o !== 1'b0) begin errors++; $display("FAIL bool_idle got=%b exp=0", m_bool_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_truncated();
        test_zero_len();
        test_random_stall();
        test_abort_restart();
`ifdef DMA_UNPACK_BOOL_EN
        test_bool();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_stream_unpacker.md
# dma_stream_unpacker

Downstream stage of the DMA accelerator wrapper. It consumes the wrapper's FIFO-view word stream (`dma_data_o`/`dma_data_valid_o`/`dma_data_ready_i`) and emits a framed, narrower feature stream to the RConvCoTM input buffer. Frames are sized in output beats, with `last` marking the final beat. Excess lanes of the final word are discarded. The block is armed per frame by the accelerator control FSM.

## Interface
Parameters:
- `DATA_W`, default `` `DMA_DATA_WIDTH `` (32): input word width; must be a multiple of `OUT_W`.
- `OUT_W`, default 8: output beat width.
- `LEN_W`, default 16: width of the frame-length field, counted in beats.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `start_i`, in, 1: arm a frame; sampled in IDLE only.
- `abort_i`, in, 1: synchronous abort; has priority over everything except `rst`.
- `frame_len_i`, in, `LEN_W`: beats in the frame; latched on `start_i`.
- `s_data_i`, in, `DATA_W`: input word; connects to the DMA wrapper data output.
- `s_valid_i`, in, 1: input word valid.
- `s_ready_o`, out, 1: input word accepted when high together with `s_valid_i`.
- `m_data_o`, out, `OUT_W`: output beat.
- `m_valid_o`, out, 1: output beat valid.
- `m_ready_i`, in, 1: downstream ready.
- `m_last_o`, out, 1: final beat of the frame.
- `busy_o`, out, 1: state is not IDLE.
- `frame_done_o`, out, 1: one-cycle pulse when a frame completes.

## Operation
- `RATIO = DATA_W/OUT_W`; lane 0 is `s_data_i[OUT_W-1:0]` and is emitted first (little-endian lane order).
- State machine: `IDLE`, `RUN`, `DONE`.
  - `IDLE -> RUN` on `start_i` with `frame_len_i != 0`. This latches `beats_left = frame_len_i` and `words_left = ceil(frame_len_i/RATIO)`.
  - `IDLE -> DONE` on `start_i` with `frame_len_i == 0`. No data moves.
  - `RUN -> DONE` on the output handshake with `m_last_o = 1`.
  - `DONE -> IDLE` unconditionally after one cycle. `frame_done_o = 1` in `DONE`.
  - Any state `-> IDLE` on `abort_i`. The held word is dropped, counters clear, and no `frame_done_o` pulse is produced.
- Holding register: one word, plus a `lane` index (`$clog2(RATIO)` bits) and a `full` flag.
- `s_ready_o = RUN & (words_left != 0) & (~full | (out_fire & lane == RATIO-1))`. Input is accepted on the same cycle the last lane drains, which gives gap-free streaming.
- On each input accept: `words_left` decrements, `lane` resets to 0, `full` is set.
- `m_valid_o = full & RUN`. `m_data_o` is lane `lane` of the held word. `m_last_o = (beats_left == 1)`.
- On each output handshake: `beats_left` decrements and `lane` increments. `full` clears when `lane == RATIO-1` (unless refilled the same cycle) or when `m_last_o` is set.
- Unused lanes of the final word are discarded and never emitted. No extra words are pulled from the DMA.
- `start_i` outside IDLE is ignored. `s_valid_i` outside RUN is ignored (`s_ready_o = 0`).
- `m_data_o`/`m_last_o` are stable while `m_valid_o & ~m_ready_i` (AXI-Stream rule). `m_valid_o` never drops without a handshake, except on `abort_i` or `rst`.

## Timing
- Reset values: `s_ready_o`, `m_valid_o`, `m_last_o`, `busy_o`, `frame_done_o` = 0; `m_data_o` = 0. State is `IDLE`, all counters 0.
- Latency: a word accepted in cycle N gives its lane 0 as `m_valid_o` in cycle N+1.
- Throughput: 1 beat per cycle sustained when `s_valid_i` and `m_ready_i` are held high.
- `frame_done_o` is asserted the cycle after the last-beat handshake. `busy_o` falls one cycle after that.
- `rst` mid-frame clears everything immediately. Partial output is not flushed.

## Configuration
- `DMA_UNPACK_BOOL_EN` defined:
  - Adds input `thresh_i` (`OUT_W` bits) and output `m_bool_o` (1 bit).
  - `m_bool_o = (m_data_o >= thresh_i)`, unsigned. It is qualified by `m_valid_o` and is 0 at reset. This supplies booleanised literals to the Tsetlin clauses.
- `DMA_UNPACK_BOOL_EN` undefined: neither port exists and there is no comparator logic.

## Structure
- `dma_utils_pkg` gains:
  - `typedef enum logic [1:0] {UNPK_IDLE, UNPK_RUN, UNPK_DONE} dma_unpk_st_t`.
  - `localparam int DMA_UNPK_OUT_W = 8`.
- Single module; lane selection is an inline indexed part-select. No sub-module.
- Elaboration assertion: `DATA_W % OUT_W == 0`.

## Test plan
- `DATA_W`=32, `frame_len`=8, words `0x44332211`, `0x88776655`, both sides always ready -> beats `0x11..0x88` on consecutive cycles; `m_last_o` on `0x88`; `frame_done_o` one cycle later; exactly 2 input accepts.
- `frame_len`=5, same words -> beats `0x11,0x22,0x33,0x44,0x55`, `last` on `0x55`. Lanes `0x66..0x88` are discarded; a third offered word is never accepted.
- `frame_len`=0 -> `frame_done_o` pulse the cycle after `start_i`; `m_valid_o` and `s_ready_o` stay 0.
- Random `m_ready_i` (50%) and random `s_valid_i` over `frame_len`=1000 -> output matches the reference byte sequence and `m_data_o` is stable under stall.
- `abort_i` after 3 beats of 8 -> idle next cycle, no `frame_done_o`. A new `start_i` with `frame_len`=4 then works normally.
- With `DMA_UNPACK_BOOL_EN`, `thresh_i`=`0x40`, beats `0x3F,0x40,0xFF,0x00` -> `m_bool_o` = 0,1,1,0.
